aes_bus_ctrl: RTL and testbench
===============================

# aes_bus_ctrl

Memory-mapped controller between the NEO430 16-bit peripheral bus and `aes_core`. Software writes the key, input block and mode through 16-bit word registers. The block then pulses the core's load strobe and tracks the core's busy output until it falls. It captures the core's 128-bit result into readable registers and raises a done flag and an optional interrupt. It sits directly upstream of `aes_core`, driving its inputs and consuming its outputs.

## Interface
- `TIMEOUT_CYCLES`, default 63: maximum number of WAIT-state cycles before the operation is aborted with an error. Must be ≥ 32.
- `clk` in 1: the single clock for the block and for `aes_core`.
- `rst_i` in 1: synchronous, active-high reset.
- `bus_en_i` in 1: bus access strobe, one cycle per access.
- `bus_we_i` in 1: 1 = write, 0 = read.
- `bus_addr_i` in 6: word address.
- `bus_wdata_i` in 16: write data.
- `bus_rdata_o` out 16: read data, valid while `bus_ack_o` = 1, otherwise 0.
- `bus_ack_o` out 1: access acknowledge.
- `irq_o` out 1: interrupt, level signal.
- `core_load_o` out 1: load strobe to `aes_core.load_i`.
- `core_key_o` out 256: to `aes_core.key_i`.
- `core_data_o` out 128: to `aes_core.data_i`.
- `core_size_o` out 2: to `aes_core.size_i`.
- `core_dec_o` out 1: to `aes_core.dec_i`.
- `core_data_i` in 128: from `aes_core.data_o`.
- `core_busy_i` in 1: from `aes_core.busy_o`.

## Operation
Address map (word addresses):
- 0x00–0x0F KEY, read/write. Word n maps to `core_key_o[255-16n -: 16]`. An AES-128 key uses words 0–7; an AES-192 key uses words 0–11.
- 0x10–0x17 DIN, read/write. Word n maps to `core_data_o[127-16n -: 16]`.
- 0x18–0x1F DOUT, read-only. Word n returns the captured result bits `[127-16n -: 16]`.
- 0x20 CTRL: `[1:0]` size (0 = 128, 1 = 192, 2 or 3 = 256), `[2]` dec, `[3]` irq_en, `[15]` start. Start is write-1, always reads 0, and is acted on only in IDLE.
- 0x21 STATUS: `[0]` busy (read-only), `[1]` done, `[2]` err. Done and err are sticky and write-1-to-clear.
- Any other address reads 0; writes to it are ignored.

Write rules:
- A write to KEY, DIN or CTRL while busy = 1 is dropped and sets err.
- A start request while busy = 1 sets err.
- A CTRL write with start = 1 in IDLE updates the mode bits and starts the FSM in the same cycle.

State machine:
- IDLE: waits for a start request.
- LOAD: `core_load_o` = 1 for exactly one cycle. KEY, DIN, size and dec are driven stable from the registers.
- ARM: one cycle, so that the core's registered busy output becomes valid. The timeout counter is cleared here.
- WAIT: the counter increments each cycle.
  - When `core_busy_i` = 0, `core_data_i` is captured into DOUT, done is set, and the FSM returns to IDLE.
  - When the counter reaches `TIMEOUT_CYCLES`, err is set, DOUT is left unchanged, and the FSM returns to IDLE.
- STATUS busy = 1 in LOAD, ARM and WAIT.
- Done and err are cleared automatically on each accepted start.
- `irq_o` = done & irq_en.
- If a hardware set and a software W1C hit the same flag in the same cycle, the set wins.

## Timing
- Reset: FSM = IDLE and all registers = 0, including KEY, DIN, DOUT and CTRL. All outputs = 0.
- Reset in the middle of an operation aborts it; no capture happens. `aes_core` has no reset, but the next LOAD restarts it cleanly.
- Bus: `bus_ack_o` and `bus_rdata_o` are registered, asserted one cycle after `bus_en_i`, for exactly one cycle.
  - A write takes effect at the clock edge that samples `bus_en_i`.
  - A read returns register contents as of that same edge.
- Start accepted at edge E:
  - LOAD during cycle E+1, ARM during E+2, WAIT from E+3.
  - Encrypt: `core_busy_i` falls (size round_max + 1) cycles after LOAD, i.e. 11, 13 or 15 cycles.
  - Decrypt: the core's busy window is 2 × (round_max + 1) cycles.
  - Done is set at the first WAIT edge that samples `core_busy_i` = 0.
- Back-to-back operations: a new start is accepted in the cycle after the FSM returns to IDLE.

## Structure
- Shared package `aes_pkg` holds:
  - address constants (`ADDR_KEY`, `ADDR_DIN`, `ADDR_DOUT`, `ADDR_CTRL`, `ADDR_STATUS`);
  - CTRL and STATUS bit indices;
  - size encodings;
  - the FSM state enum.
- No sub-module: a single flat module. The top level instantiates `aes_bus_ctrl` beside `aes_core`.

## Test plan
- AES-128 encrypt: KEY = 000102030405060708090a0b0c0d0e0f (words 0–7), DIN = 00112233445566778899aabbccddeeff, CTRL = 0x8000 → `core_load_o` pulses once. Done after 11 busy cycles; DOUT = 69c4e0d86a7b0430d8cdb78070b4c55a.
- AES-256 decrypt: KEY = 000102…1f, DIN = 8ea2b7ca516745bfeafc49904b496089, CTRL = 0x8006 → DOUT = 00112233445566778899aabbccddeeff.
- Mid-run access: KEY write plus a second start while busy → both dropped, err = 1, result still correct. STATUS write 0x0006 → done = 0, err = 0.
- IRQ: CTRL = 0x8008 → `irq_o` rises with done. Write STATUS 0x0002 in the same cycle the next done sets → done stays 1.
- Timeout: hold `core_busy_i` = 1 → err = 1 after 63 WAIT cycles, DOUT unchanged, FSM back in IDLE.
- Reset in WAIT: `rst_i` pulse → all outputs 0. A new start afterwards completes normally.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES bus controller.
// Address map, register bit positions, size codes and FSM states.
package aes_pkg;

    localparam logic [5:0] ADDR_KEY    = 6'h00;
    localparam logic [5:0] ADDR_DIN    = 6'h10;
    localparam logic [5:0] ADDR_DOUT   = 6'h18;
    localparam logic [5:0] ADDR_CTRL   = 6'h20;
    localparam logic [5:0] ADDR_STATUS = 6'h21;

    localparam int CTRL_DEC    = 2;
    localparam int CTRL_IRQ_EN = 3;
    localparam int CTRL_START  = 15;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    localparam logic [1:0] SIZE_128 = 2'd0;
    localparam logic [1:0] SIZE_192 = 2'd1;
    localparam logic [1:0] SIZE_256 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_WAIT
    } state_t;

endpackage

// File: rtl/aes_bus_ctrl.sv
// NEO430 bus front-end for aes_core: word registers, load/busy
// sequencing with timeout, result capture, done/err flags and irq.
module aes_bus_ctrl
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         bus_en_i,
    input  logic         bus_we_i,
    input  logic [5:0]   bus_addr_i,
    input  logic [15:0]  bus_wdata_i,
    output logic [15:0]  bus_rdata_o,
    output logic         bus_ack_o,
    output logic         irq_o,
    output logic         core_load_o,
    output logic [255:0] core_key_o,
    output logic [127:0] core_data_o,
    output logic [1:0]   core_size_o,
    output logic         core_dec_o,
    input  logic [127:0] core_data_i,
    input  logic         core_busy_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t         state;
    state_t         state_nxt;
    logic [255:0]   key_q;
    logic [127:0]   din_q;
    logic [127:0]   dout_q;
    logic [1:0]     size_q;
    logic           dec_q;
    logic           irq_en_q;
    logic           done_q;
    logic           err_q;
    logic [CW-1:0]  cnt_q;
    logic           ack_q;
    logic [15:0]    rdata_q;
    logic [15:0]    rdata_nxt;

    logic wr;
    logic rd;
    logic busy;
    logic sel_key;
    logic sel_din;
    logic sel_dout;
    logic sel_ctrl;
    logic sel_stat;
    logic start;
    logic cfg_drop;
    logic wait_done;
    logic wait_tmo;

    assign wr       = bus_en_i & bus_we_i;
    assign rd       = bus_en_i & ~bus_we_i;
    assign busy     = (state != ST_IDLE);
    assign sel_key  = (bus_addr_i[5:4] == ADDR_KEY[5:4]);
    assign sel_din  = (bus_addr_i[5:3] == ADDR_DIN[5:3]);
    assign sel_dout = (bus_addr_i[5:3] == ADDR_DOUT[5:3]);
    assign sel_ctrl = (bus_addr_i == ADDR_CTRL);
    assign sel_stat = (bus_addr_i == ADDR_STATUS);

    assign start    = wr & sel_ctrl & bus_wdata_i[CTRL_START] & ~busy;
    assign cfg_drop = wr & (sel_key | sel_din | sel_ctrl) & busy;

    // Busy low wins over a simultaneous timeout.
    assign wait_done = (state == ST_WAIT) & ~core_busy_i;
    assign wait_tmo  = (state == ST_WAIT) & core_busy_i &
                       (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_ARM;
            ST_ARM:  state_nxt = ST_WAIT;
            ST_WAIT: if (wait_done || wait_tmo) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            key_q    <= '0;
            din_q    <= '0;
            dout_q   <= '0;
            size_q   <= SIZE_128;
            dec_q    <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ack_q   <= bus_en_i;
            rdata_q <= rdata_nxt;

            if (wr && !busy) begin
                if (sel_key)
                    key_q[{~bus_addr_i[3:0], 4'b0000} +: 16] <= bus_wdata_i;
                if (sel_din)
                    din_q[{~bus_addr_i[2:0], 4'b0000} +: 16] <= bus_wdata_i;
                if (sel_ctrl) begin
                    size_q   <= bus_wdata_i[1:0];
                    dec_q    <= bus_wdata_i[CTRL_DEC];
                    irq_en_q <= bus_wdata_i[CTRL_IRQ_EN];
                end
            end

            // Software clear first so a same-cycle hardware set overrides it.
            if (start) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                if (wr && sel_stat && bus_wdata_i[STAT_DONE]) done_q <= 1'b0;
                if (wr && sel_stat && bus_wdata_i[STAT_ERR])  err_q  <= 1'b0;
                if (wait_done)             done_q <= 1'b1;
                if (wait_tmo || cfg_drop)  err_q  <= 1'b1;
            end

            if (wait_done) dout_q <= core_data_i;

            if (state == ST_ARM)       cnt_q <= '0;
            else if (state == ST_WAIT) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        rdata_nxt = '0;
        if (rd) begin
            unique case (1'b1)
                sel_key:  rdata_nxt = key_q[{~bus_addr_i[3:0], 4'b0000} +: 16];
                sel_din:  rdata_nxt = din_q[{~bus_addr_i[2:0], 4'b0000} +: 16];
                sel_dout: rdata_nxt = dout_q[{~bus_addr_i[2:0], 4'b0000} +: 16];
                sel_ctrl: begin
                    rdata_nxt[1:0]         = size_q;
                    rdata_nxt[CTRL_DEC]    = dec_q;
                    rdata_nxt[CTRL_IRQ_EN] = irq_en_q;
                end
                sel_stat: begin
                    rdata_nxt[STAT_BUSY] = busy;
                    rdata_nxt[STAT_DONE] = done_q;
                    rdata_nxt[STAT_ERR]  = err_q;
                end
                default: rdata_nxt = '0;
            endcase
        end
    end

    assign bus_rdata_o = rdata_q;
    assign bus_ack_o   = ack_q;
    assign irq_o       = done_q & irq_en_q;
    assign core_load_o = (state == ST_LOAD);
    assign core_key_o  = key_q;
    assign core_data_o = din_q;
    assign core_size_o = size_q;
    assign core_dec_o  = dec_q;

endmodule

// File: tb/tb_aes_bus_ctrl.sv
// Directed bench for aes_bus_ctrl with a cycle-level aes_core stand-in
// that returns known FIPS-197 results for the expected key/data/mode.
module tb_aes_bus_ctrl;

    localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] BAD   = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         bus_en_i = 1'b0;
    logic         bus_we_i = 1'b0;
    logic [5:0]   bus_addr_i = '0;
    logic [15:0]  bus_wdata_i = '0;
    logic [15:0]  bus_rdata_o;
    logic         bus_ack_o;
    logic         irq_o;
    logic         core_load_o;
    logic [255:0] core_key_o;
    logic [127:0] core_data_o;
    logic [1:0]   core_size_o;
    logic         core_dec_o;
    logic [127:0] core_data_i;
    logic         core_busy_i;

    int vecs = 0;
    int errs = 0;
    int loads = 0;

    logic [127:0] m_out = '0;
    logic         m_busy = 1'b0;
    int           m_rem = 0;
    logic         hold_busy = 1'b0;

    aes_bus_ctrl dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .bus_en_i    (bus_en_i),
        .bus_we_i    (bus_we_i),
        .bus_addr_i  (bus_addr_i),
        .bus_wdata_i (bus_wdata_i),
        .bus_rdata_o (bus_rdata_o),
        .bus_ack_o   (bus_ack_o),
        .irq_o       (irq_o),
        .core_load_o (core_load_o),
        .core_key_o  (core_key_o),
        .core_data_o (core_data_o),
        .core_size_o (core_size_o),
        .core_dec_o  (core_dec_o),
        .core_data_i (core_data_i),
        .core_busy_i (core_busy_i)
    );

    always #5 clk = ~clk;

    function automatic int nlen(input logic [1:0] s, input logic d);
        int r;
        r = (s == 2'd0) ? 11 : (s == 2'd1) ? 13 : 15;
        return d ? 2 * r : r;
    endfunction

    function automatic logic [127:0] model_result(
        input logic [255:0] k, input logic [127:0] din,
        input logic [1:0] s, input logic d);
        if (!d && s == 2'd0 && k[255:128] == K128 && din == PT)
            return CT128;
        if (d && s[1] && k == K256 && din == CT256)
            return PT;
        return BAD;
    endfunction

    always @(posedge clk) begin
        if (core_load_o) begin
            loads  <= loads + 1;
            m_busy <= 1'b1;
            m_rem  <= nlen(core_size_o, core_dec_o) - 1;
            m_out  <= model_result(core_key_o, core_data_o,
                                   core_size_o, core_dec_o);
        end else if (m_busy) begin
            if (m_rem > 1) m_rem <= m_rem - 1;
            else m_busy <= 1'b0;
        end
    end

    assign core_busy_i = m_busy | hold_busy;
    assign core_data_i = m_out;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        bus_en_i = 1'b1;
        bus_we_i = 1'b1;
        bus_addr_i = a;
        bus_wdata_i = d;
        @(posedge clk);
        #1;
        bus_en_i = 1'b0;
        bus_we_i = 1'b0;
    endtask

    task automatic bus_rd(input logic [5:0] a, output logic [15:0] d);
        @(negedge clk);
        bus_en_i = 1'b1;
        bus_we_i = 1'b0;
        bus_addr_i = a;
        @(posedge clk);
        #1;
        bus_en_i = 1'b0;
        d = bus_rdata_o;
        chk("rd_ack", {255'b0, bus_ack_o}, 256'd1);
    endtask

    task automatic wr_key(input logic [255:0] k, input int nwords);
        for (int n = 0; n < nwords; n++)
            bus_wr(6'(n), k[255 - 16 * n -: 16]);
    endtask

    task automatic wr_din(input logic [127:0] v);
        for (int n = 0; n < 8; n++)
            bus_wr(6'(16 + n), v[127 - 16 * n -: 16]);
    endtask

    task automatic rd_dout(output logic [127:0] v);
        logic [15:0] w;
        for (int n = 0; n < 8; n++) begin
            bus_rd(6'(24 + n), w);
            v[127 - 16 * n -: 16] = w;
        end
    endtask

    task automatic wait_idle();
        logic [15:0] s;
        int n;
        n = 0;
        do begin
            bus_rd(6'h21, s);
            n++;
        end while (s[0] && n < 100);
        chk("op_end", {255'b0, s[0]}, 256'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        logic [15:0]  r;
        logic [127:0] d;
        int           l0;
        int           k;

        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk("rst_key", core_key_o, 256'd0);
        chk("rst_din", {128'd0, core_data_o}, 256'd0);
        chk("rst_misc", {235'd0, bus_rdata_o, bus_ack_o, irq_o, core_load_o,
            core_size_o, core_dec_o}, 256'd0);
        bus_rd(6'h21, r);
        chk("rst_status", {240'd0, r}, 256'd0);
        bus_rd(6'h20, r);
        chk("rst_ctrl", {240'd0, r}, 256'd0);
        @(posedge clk);
        #1;
        chk("idle_bus", {239'd0, bus_ack_o, bus_rdata_o}, 256'd0);

        // AES-128 encrypt
        wr_key({K128, 128'd0}, 8);
        wr_din(PT);
        chk("key_out", core_key_o, {K128, 128'd0});
        bus_rd(6'h03, r);
        chk("key_rd3", {240'd0, r}, 256'h0607);
        l0 = loads;
        bus_wr(6'h20, 16'h8000);
        chk("load_hi", {255'd0, core_load_o}, 256'd1);
        @(posedge clk);
        #1;
        chk("load_lo", {255'd0, core_load_o}, 256'd0);
        wait_idle();
        chk("load_cnt", 256'(loads - l0), 256'd1);
        bus_rd(6'h21, r);
        chk("st_done", {240'd0, r}, 256'h0002);
        bus_rd(6'h20, r);
        chk("ctrl_rd", {240'd0, r}, 256'h0000);
        chk("no_irq", {255'd0, irq_o}, 256'd0);
        rd_dout(d);
        chk("dout_128", {128'd0, d}, {128'd0, CT128});

        // AES-256 decrypt with dropped accesses mid-run
        wr_key(K256, 16);
        wr_din(CT256);
        l0 = loads;
        bus_wr(6'h20, 16'h8006);
        bus_rd(6'h21, r);
        chk("st_busy", {240'd0, r}, 256'h0001);
        bus_wr(6'h00, 16'hffff);
        bus_wr(6'h20, 16'h8006);
        wait_idle();
        chk("drop_load", 256'(loads - l0), 256'd1);
        bus_rd(6'h21, r);
        chk("st_derr", {240'd0, r}, 256'h0006);
        bus_rd(6'h00, r);
        chk("key_kept", {240'd0, r}, 256'h0001);
        rd_dout(d);
        chk("dout_256d", {128'd0, d}, {128'd0, PT});
        bus_wr(6'h21, 16'h0006);
        bus_rd(6'h21, r);
        chk("w1c_both", {240'd0, r}, 256'd0);

        // IRQ latency and set-beats-clear race
        wr_din(PT);
        bus_wr(6'h20, 16'h8008);
        k = 0;
        while (!irq_o && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("irq_lat", 256'(k), 256'd12);
        bus_wr(6'h20, 16'h8008);
        chk("irq_clr", {255'd0, irq_o}, 256'd0);
        repeat (11) @(posedge clk);
        bus_wr(6'h21, 16'h0002);
        chk("race_irq", {255'd0, irq_o}, 256'd1);
        bus_rd(6'h21, r);
        chk("race_done", {240'd0, r}, 256'h0002);
        bus_wr(6'h21, 16'h0002);
        bus_rd(6'h21, r);
        chk("w1c_done", {240'd0, r}, 256'd0);
        chk("irq_off", {255'd0, irq_o}, 256'd0);

        // Timeout with busy held high
        wr_din({8{16'h1111}});
        hold_busy = 1'b1;
        bus_wr(6'h20, 16'h8000);
        repeat (64) @(posedge clk);
        bus_rd(6'h21, r);
        chk("tmo_pre", {240'd0, r}, 256'h0001);
        bus_rd(6'h21, r);
        chk("tmo_err", {240'd0, r}, 256'h0004);
        hold_busy = 1'b0;
        bus_rd(6'h18, r);
        chk("tmo_dout", {240'd0, r}, 256'h69c4);

        // Reset in WAIT, then a clean operation
        wr_din(PT);
        bus_wr(6'h20, 16'h8009);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk("wrst_key", core_key_o, 256'd0);
        chk("wrst_din", {128'd0, core_data_o}, 256'd0);
        chk("wrst_misc", {235'd0, bus_rdata_o, bus_ack_o, irq_o, core_load_o,
            core_size_o, core_dec_o}, 256'd0);
        bus_rd(6'h21, r);
        chk("wrst_st", {240'd0, r}, 256'd0);
        bus_rd(6'h18, r);
        chk("wrst_dout", {240'd0, r}, 256'd0);
        bus_rd(6'h2a, r);
        chk("unmapped", {240'd0, r}, 256'd0);
        wr_key({K128, 128'd0}, 8);
        wr_din(PT);
        bus_wr(6'h20, 16'h8000);
        wait_idle();
        bus_rd(6'h21, r);
        chk("post_done", {240'd0, r}, 256'h0002);
        rd_dout(d);
        chk("post_dout", {128'd0, d}, {128'd0, CT128});

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
